axi_r_beat_gen: RTL and testbench

AXI_R_BEAT_GEN -- requirements
Module: axi_r_beat_gen

---
 rtl/axi_pkg.sv | 33 +++
 rtl/axi_r_beat_gen_if.sv | 49 ++++
 rtl/axi_burst_addr_next.sv | 33 +++
 rtl/axi_r_beat_gen.sv | 183 ++++++++++++++++++
 tb/tb_axi_r_beat_gen.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
// Shared AXI encodings and the read beat generator state set.
package axi_pkg;

    localparam int LEN_WIDTH  = 8;
    localparam int SIZE_WIDTH = 3;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_DATA,
        ST_SEND,
        ST_ERR_SEND
    } state_e;

    function automatic logic burst_is_legal(input logic [1:0] burst);
        return burst != BURST_RSVD;
    endfunction

endpackage

// File: rtl/axi_r_beat_gen_if.sv
// AR request, single-word backend and R beat signals of the read beat generator.
interface axi_r_beat_gen_if #(
    parameter int ID_WIDTH   = 16,
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 10,
    parameter int ADDR_WIDTH = 32
);
    import axi_pkg::*;

    logic                  ar_valid;
    logic                  ar_ready;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [LEN_WIDTH-1:0]  ar_len;
    logic [SIZE_WIDTH-1:0] ar_size;
    logic [1:0]            ar_burst;
    logic [ID_WIDTH-1:0]   ar_id;
    logic [USER_WIDTH-1:0] ar_user;

    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_gnt;
    logic                  rd_rvalid;
    logic [DATA_WIDTH-1:0] rd_rdata;
    logic                  rd_err;

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_resp;
    logic [USER_WIDTH-1:0] r_user;
    logic [ID_WIDTH-1:0]   r_id;
    logic                  r_last;
    logic                  r_ready;

    // Beat generator side: accepts AR, drives the backend, produces R beats.
    modport slave (
        input  ar_valid, ar_addr, ar_len, ar_size, ar_burst, ar_id, ar_user,
        input  rd_gnt, rd_rvalid, rd_rdata, rd_err, r_ready,
        output ar_ready, rd_req, rd_addr,
        output r_valid, r_data, r_resp, r_user, r_id, r_last
    );

    modport master (
        output ar_valid, ar_addr, ar_len, ar_size, ar_burst, ar_id, ar_user,
        output rd_gnt, rd_rvalid, rd_rdata, rd_err, r_ready,
        input  ar_ready, rd_req, rd_addr,
        input  r_valid, r_data, r_resp, r_user, r_id, r_last
    );

endinterface

// File: rtl/axi_burst_addr_next.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts.
module axi_burst_addr_next
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [SIZE_WIDTH-1:0] size_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  burst_e                burst_i,
    output logic [ADDR_WIDTH-1:0] next_addr_o
);

    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] incr_addr;

    assign step      = ADDR_WIDTH'(1) << size_i;
    // Window is (len+1) beats of (1<<size) bytes, aligned to its own size.
    assign wrap_mask = ((ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_i) - ADDR_WIDTH'(1);
    assign incr_addr = addr_i + step;

    always_comb begin
        // NOTE: default first so every path assigns the output and no latch is inferred.
        next_addr_o = addr_i;
        unique case (burst_i)
            BURST_INCR:  next_addr_o = incr_addr;
            BURST_WRAP:  next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
            default:     next_addr_o = addr_i;
        endcase
    end

endmodule

// File: rtl/axi_r_beat_gen.sv
// Turns one AXI read burst at a time into single-word backend reads and R beats.
module axi_r_beat_gen
    import axi_pkg::*;
#(
    parameter int ID_WIDTH   = 16,
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 10,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  ar_valid_i,
    output logic                  ar_ready_o,
    input  logic [ADDR_WIDTH-1:0] ar_addr_i,
    input  logic [LEN_WIDTH-1:0]  ar_len_i,
    input  logic [SIZE_WIDTH-1:0] ar_size_i,
    input  logic [1:0]            ar_burst_i,
    input  logic [ID_WIDTH-1:0]   ar_id_i,
    input  logic [USER_WIDTH-1:0] ar_user_i,

    output logic                  rd_req_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    input  logic                  rd_gnt_i,
    input  logic                  rd_rvalid_i,
    input  logic [DATA_WIDTH-1:0] rd_rdata_i,
    input  logic                  rd_err_i,

    output logic                  r_valid_o,
    output logic [DATA_WIDTH-1:0] r_data_o,
    output logic [1:0]            r_resp_o,
    output logic [USER_WIDTH-1:0] r_user_o,
    output logic [ID_WIDTH-1:0]   r_id_o,
    output logic                  r_last_o,
    input  logic                  r_ready_i
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [LEN_WIDTH-1:0]  len_q,   len_d;
    logic [LEN_WIDTH-1:0]  cnt_q,   cnt_d;
    logic [SIZE_WIDTH-1:0] size_q,  size_d;
    burst_e                burst_q, burst_d;
    logic [ID_WIDTH-1:0]   id_q,    id_d;
    logic [USER_WIDTH-1:0] user_q,  user_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
    resp_e                 resp_q,  resp_d;

    logic [ADDR_WIDTH-1:0] addr_next;
    logic                  last_beat;
    logic                  beat_phase;

    axi_burst_addr_next #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_next (
        .addr_i      (addr_q),
        .size_i      (size_q),
        .len_i       (len_q),
        .burst_i     (burst_q),
        .next_addr_o (addr_next)
    );

    assign last_beat  = (cnt_q == len_q);
    assign beat_phase = (state_q == ST_SEND) || (state_q == ST_ERR_SEND);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        burst_d = burst_q;
        id_d    = id_q;
        user_d  = user_q;
        data_d  = data_q;
        resp_d  = resp_q;

        ar_ready_o = 1'b0;
        rd_req_o   = 1'b0;
        r_valid_o  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                ar_ready_o = 1'b1;
                if (ar_valid_i) begin
                    addr_d  = ar_addr_i;
                    len_d   = ar_len_i;
                    size_d  = ar_size_i;
                    burst_d = burst_e'(ar_burst_i);
                    id_d    = ar_id_i;
                    user_d  = ar_user_i;
                    cnt_d   = '0;
                    if (burst_is_legal(ar_burst_i)) begin
                        state_d = ST_REQ;
                    end else begin
                        // Reserved burst type: answer every beat with an error, never touch the backend.
                        data_d  = '0;
                        resp_d  = RESP_SLVERR;
                        state_d = ST_ERR_SEND;
                    end
                end
            end

            ST_REQ: begin
                rd_req_o = 1'b1;
                if (rd_gnt_i) begin
                    state_d = ST_WAIT_DATA;
                end
            end

            ST_WAIT_DATA: begin
                if (rd_rvalid_i) begin
                    data_d  = rd_rdata_i;
                    resp_d  = rd_err_i ? RESP_SLVERR : RESP_OKAY;
                    state_d = ST_SEND;
                end
            end

            ST_SEND: begin
                r_valid_o = 1'b1;
                if (r_ready_i) begin
                    if (last_beat) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        addr_d  = addr_next;
                        state_d = ST_REQ;
                    end
                end
            end

            ST_ERR_SEND: begin
                r_valid_o = 1'b1;
                if (r_ready_i) begin
                    if (last_beat) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            size_q  <= '0;
            burst_q <= BURST_FIXED;
            id_q    <= '0;
            user_q  <= '0;
            data_q  <= '0;
            resp_q  <= RESP_OKAY;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of its peers.
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            id_q    <= id_d;
            user_q  <= user_d;
            data_q  <= data_d;
            resp_q  <= resp_d;
        end
    end

    assign rd_addr_o = addr_q;
    assign r_data_o  = data_q;
    assign r_resp_o  = resp_q;
    assign r_id_o    = id_q;
    assign r_user_o  = user_q;
    assign r_last_o  = beat_phase && last_beat;

endmodule

// File: tb/tb_axi_r_beat_gen.sv
// Directed scoreboard bench: stimulus queues expected backend addresses and R beats, monitors compare.
module tb_axi_r_beat_gen;
    import axi_pkg::*;

    localparam int ID_W   = 16;
    localparam int DATA_W = 32;
    localparam int USER_W = 10;
    localparam int ADDR_W = 32;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
        logic [ID_W-1:0]   id;
        logic [USER_W-1:0] user;
    } beat_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    axi_r_beat_gen_if #(
        .ID_WIDTH (ID_W), .DATA_WIDTH (DATA_W), .USER_WIDTH (USER_W), .ADDR_WIDTH (ADDR_W)
    ) bus ();

    axi_r_beat_gen #(
        .ID_WIDTH (ID_W), .DATA_WIDTH (DATA_W), .USER_WIDTH (USER_W), .ADDR_WIDTH (ADDR_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .ar_valid_i  (bus.ar_valid),
        .ar_ready_o  (bus.ar_ready),
        .ar_addr_i   (bus.ar_addr),
        .ar_len_i    (bus.ar_len),
        .ar_size_i   (bus.ar_size),
        .ar_burst_i  (bus.ar_burst),
        .ar_id_i     (bus.ar_id),
        .ar_user_i   (bus.ar_user),
        .rd_req_o    (bus.rd_req),
        .rd_addr_o   (bus.rd_addr),
        .rd_gnt_i    (bus.rd_gnt),
        .rd_rvalid_i (bus.rd_rvalid),
        .rd_rdata_i  (bus.rd_rdata),
        .rd_err_i    (bus.rd_err),
        .r_valid_o   (bus.r_valid),
        .r_data_o    (bus.r_data),
        .r_resp_o    (bus.r_resp),
        .r_user_o    (bus.r_user),
        .r_id_o      (bus.r_id),
        .r_last_o    (bus.r_last),
        .r_ready_i   (bus.r_ready)
    );

    beat_t             exp_beats[$];
    logic [ADDR_W-1:0] exp_addrs[$];
    logic              exp_errs[$];

    int n_checks   = 0;
    int n_errors   = 0;
    int beats_seen = 0;

    int   be_gnt_delay = 0;
    logic be_hold      = 1'b0;
    logic be_waiting   = 1'b0;
    logic be_release   = 1'b0;

    beat_t             mon_act;
    beat_t             mon_exp;
    logic [ADDR_W-1:0] be_addr;
    logic              be_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_rd(input logic [ADDR_W-1:0] addr, input logic err);
        exp_addrs.push_back(addr);
        exp_errs.push_back(err);
    endtask

    task automatic push_beat(input logic [DATA_W-1:0] data, input logic [1:0] resp, input logic last,
                             input logic [ID_W-1:0] id, input logic [USER_W-1:0] user);
        beat_t b;
        b.data = data;
        b.resp = resp;
        b.last = last;
        b.id   = id;
        b.user = user;
        exp_beats.push_back(b);
    endtask

    // Returns at posedge+1 just after the AR handshake edge.
    task automatic send_ar(input logic [ADDR_W-1:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [ID_W-1:0] id, input logic [USER_W-1:0] user);
        int t = 0;
        while (!bus.ar_ready && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        check("ar_ready_before_request", 64'(bus.ar_ready), 64'd1);
        bus.ar_addr  = addr;
        bus.ar_len   = len;
        bus.ar_size  = size;
        bus.ar_burst = burst;
        bus.ar_id    = id;
        bus.ar_user  = user;
        bus.ar_valid = 1'b1;
        @(posedge clk); #1;
        bus.ar_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while (!(bus.ar_ready && exp_beats.size() == 0) && t < 600) begin
            @(posedge clk); #1;
            t++;
        end
        n_checks++;
        if (t >= 600) begin
            n_errors++;
            $display("FAIL %s: burst not complete after %0d cycles, %0d beats still expected", name, t, exp_beats.size());
        end
    endtask

    // R-channel monitor: a beat is handed over on the next posedge when valid and ready are both high.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.r_valid && bus.r_ready) begin
                mon_act.data = bus.r_data;
                mon_act.resp = bus.r_resp;
                mon_act.last = bus.r_last;
                mon_act.id   = bus.r_id;
                mon_act.user = bus.r_user;
                beats_seen++;
                n_checks++;
                if (exp_beats.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_r_beat: got data=0x%0h resp=%b last=%b, expected no beat",
                             mon_act.data, mon_act.resp, mon_act.last);
                end else begin
                    mon_exp = exp_beats.pop_front();
                    if (mon_act !== mon_exp) begin
                        n_errors++;
                        $display("FAIL r_beat: got data=0x%0h resp=%b last=%b id=0x%0h user=0x%0h, expected data=0x%0h resp=%b last=%b id=0x%0h user=0x%0h",
                                 mon_act.data, mon_act.resp, mon_act.last, mon_act.id, mon_act.user,
                                 mon_exp.data, mon_exp.resp, mon_exp.last, mon_exp.id, mon_exp.user);
                    end
                end
            end
        end
    end

    // Backend model: grant after an optional delay, return data one cycle after the grant.
    initial begin
        bus.rd_gnt    = 1'b0;
        bus.rd_rvalid = 1'b0;
        bus.rd_rdata  = '0;
        bus.rd_err    = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && bus.rd_req) begin
                be_addr = bus.rd_addr;
                be_err  = 1'b0;
                n_checks++;
                if (exp_addrs.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_rd_req: got rd_addr=0x%0h, expected no backend request", bus.rd_addr);
                end else begin
                    be_err = exp_errs.pop_front();
                    mon_exp.data = exp_addrs.pop_front();
                    if (bus.rd_addr !== mon_exp.data) begin
                        n_errors++;
                        $display("FAIL rd_addr: got 0x%0h, expected 0x%0h", bus.rd_addr, mon_exp.data);
                    end
                end
                for (int i = 0; i < be_gnt_delay; i++) begin
                    @(negedge clk);
                    check("rd_req_held_until_gnt", 64'(bus.rd_req), 64'd1);
                end
                bus.rd_gnt = 1'b1;
                @(negedge clk);
                bus.rd_gnt = 1'b0;
                if (be_hold) begin
                    be_waiting = 1'b1;
                    wait (be_release);
                    @(negedge clk);
                end
                bus.rd_rvalid = 1'b1;
                bus.rd_rdata  = 32'hA5A5_0000 | {16'h0000, be_addr[15:0]};
                bus.rd_err    = be_err;
                @(negedge clk);
                bus.rd_rvalid = 1'b0;
                bus.rd_err    = 1'b0;
                be_waiting    = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        int base;

        rst          = 1'b1;
        bus.ar_valid = 1'b0;
        bus.ar_addr  = '0;
        bus.ar_len   = '0;
        bus.ar_size  = '0;
        bus.ar_burst = '0;
        bus.ar_id    = '0;
        bus.ar_user  = '0;
        bus.r_ready  = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("reset_ar_ready", 64'(bus.ar_ready), 64'd1);
        check("reset_rd_req",   64'(bus.rd_req),   64'd0);
        check("reset_r_valid",  64'(bus.r_valid),  64'd0);
        check("reset_r_last",   64'(bus.r_last),   64'd0);
        check("reset_r_resp",   64'(bus.r_resp),   64'd0);
        check("reset_r_data",   64'(bus.r_data),   64'd0);
        check("reset_r_id",     64'(bus.r_id),     64'd0);
        check("reset_r_user",   64'(bus.r_user),   64'd0);
        check("reset_rd_addr",  64'(bus.rd_addr),  64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // INCR 0x100, len 3, size 2
        push_rd(32'h100, 1'b0); push_rd(32'h104, 1'b0); push_rd(32'h108, 1'b0); push_rd(32'h10C, 1'b0);
        push_beat(32'hA5A5_0100, 2'b00, 1'b0, 16'h01A1, 10'h0A1);
        push_beat(32'hA5A5_0104, 2'b00, 1'b0, 16'h01A1, 10'h0A1);
        push_beat(32'hA5A5_0108, 2'b00, 1'b0, 16'h01A1, 10'h0A1);
        push_beat(32'hA5A5_010C, 2'b00, 1'b1, 16'h01A1, 10'h0A1);
        send_ar(32'h100, 8'd3, 3'd2, BURST_INCR, 16'h01A1, 10'h0A1);
        check("incr_rd_req_one_cycle_after_ar", 64'(bus.rd_req), 64'd1);
        check("incr_ar_ready_low_when_busy",    64'(bus.ar_ready), 64'd0);
        wait_done("incr_burst");

        // WRAP 0x38, len 3, size 2, with a slow grant
        be_gnt_delay = 2;
        push_rd(32'h38, 1'b0); push_rd(32'h3C, 1'b0); push_rd(32'h30, 1'b0); push_rd(32'h34, 1'b0);
        push_beat(32'hA5A5_0038, 2'b00, 1'b0, 16'h02B2, 10'h0B2);
        push_beat(32'hA5A5_003C, 2'b00, 1'b0, 16'h02B2, 10'h0B2);
        push_beat(32'hA5A5_0030, 2'b00, 1'b0, 16'h02B2, 10'h0B2);
        push_beat(32'hA5A5_0034, 2'b00, 1'b1, 16'h02B2, 10'h0B2);
        send_ar(32'h38, 8'd3, 3'd2, BURST_WRAP, 16'h02B2, 10'h0B2);
        wait_done("wrap_burst");
        be_gnt_delay = 0;

        // FIXED 0x200, len 1, backend error on the first beat only
        push_rd(32'h200, 1'b1); push_rd(32'h200, 1'b0);
        push_beat(32'hA5A5_0200, 2'b10, 1'b0, 16'h0333, 10'h133);
        push_beat(32'hA5A5_0200, 2'b00, 1'b1, 16'h0333, 10'h133);
        send_ar(32'h200, 8'd1, 3'd2, BURST_FIXED, 16'h0333, 10'h133);
        wait_done("fixed_err_burst");

        // Reserved burst type, len 2: three SLVERR beats of zero data, no backend traffic
        push_beat(32'h0000_0000, 2'b10, 1'b0, 16'h03C3, 10'h0C3);
        push_beat(32'h0000_0000, 2'b10, 1'b0, 16'h03C3, 10'h0C3);
        push_beat(32'h0000_0000, 2'b10, 1'b1, 16'h03C3, 10'h0C3);
        send_ar(32'h700, 8'd2, 3'd2, BURST_RSVD, 16'h03C3, 10'h0C3);
        check("rsvd_no_rd_req",        64'(bus.rd_req),  64'd0);
        check("rsvd_r_valid_next_cyc", 64'(bus.r_valid), 64'd1);
        wait_done("rsvd_burst");

        // INCR 0x400 with r_ready held low for 5 cycles while beat 2 is presented
        base = beats_seen;
        push_rd(32'h400, 1'b0); push_rd(32'h404, 1'b0); push_rd(32'h408, 1'b0); push_rd(32'h40C, 1'b0);
        push_beat(32'hA5A5_0400, 2'b00, 1'b0, 16'h0455, 10'h155);
        push_beat(32'hA5A5_0404, 2'b00, 1'b0, 16'h0455, 10'h155);
        push_beat(32'hA5A5_0408, 2'b00, 1'b0, 16'h0455, 10'h155);
        push_beat(32'hA5A5_040C, 2'b00, 1'b1, 16'h0455, 10'h155);
        send_ar(32'h400, 8'd3, 3'd2, BURST_INCR, 16'h0455, 10'h155);
        t = 0;
        while (!(bus.r_valid && beats_seen == base + 1) && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check("stall_beat2_presented", 64'(t < 200), 64'd1);
        bus.r_ready = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            check("stall_r_valid", 64'(bus.r_valid), 64'd1);
            check("stall_r_data",  64'(bus.r_data),  64'hA5A5_0404);
            check("stall_r_resp",  64'(bus.r_resp),  64'd0);
            check("stall_r_last",  64'(bus.r_last),  64'd0);
            check("stall_r_id",    64'(bus.r_id),    64'h0455);
            check("stall_r_user",  64'(bus.r_user),  64'h155);
            check("stall_no_rd_req", 64'(bus.rd_req), 64'd0);
        end
        bus.r_ready = 1'b1;
        wait_done("stall_burst");

        // Reset while waiting for backend data; the late data must not produce a beat
        be_hold = 1'b1;
        push_rd(32'h500, 1'b0);
        send_ar(32'h500, 8'd0, 3'd2, BURST_INCR, 16'h0566, 10'h166);
        t = 0;
        while (!be_waiting && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("rst_reached_wait_data", 64'(be_waiting), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_ar_ready", 64'(bus.ar_ready), 64'd1);
        check("rst_mid_r_valid",  64'(bus.r_valid),  64'd0);
        check("rst_mid_rd_req",   64'(bus.rd_req),   64'd0);
        check("rst_mid_rd_addr",  64'(bus.rd_addr),  64'd0);
        rst = 1'b0;
        be_release = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            check("late_data_no_r_valid", 64'(bus.r_valid),  64'd0);
            check("late_data_idle",       64'(bus.ar_ready), 64'd1);
        end
        be_hold    = 1'b0;
        be_release = 1'b0;

        // Recovery: single-beat byte-sized INCR after the reset
        push_rd(32'h601, 1'b0);
        push_beat(32'hA5A5_0601, 2'b00, 1'b1, 16'h0677, 10'h177);
        send_ar(32'h601, 8'd0, 3'd0, BURST_INCR, 16'h0677, 10'h177);
        wait_done("recovery_burst");

        repeat (3) @(posedge clk);
        #1;
        check("backend_queue_drained", 64'(exp_addrs.size()), 64'd0);
        check("beat_queue_drained",    64'(exp_beats.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
